// File: rtl/store_trace_buffer.sv
// Store trace FIFO: captures processor stores and derives a sticky
// pass/fail verdict from a magic address/data pair.
module store_trace_buffer #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                store_cnt,
  output logic                       pass,
  output logic                       fail,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   store_cnt_q, store_cnt_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          done_q, done_d;

  logic capture, full, push, pop;
  logic pass_hit, scratch_hit;

  always_comb begin
    capture     = memwrite && !done_q;
    full        = (count_q == FULL);
    pop         = (count_q != '0) && out_ready;
    // a full FIFO still accepts a push when the head leaves this edge
    push        = capture && (!full || pop);
    pass_hit    = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
    scratch_hit = (dataadr == SCRATCH_ADDR);

    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d  = overflow_q | (capture && full && !pop);
    store_cnt_d = store_cnt_q;
    if (capture && store_cnt_q != 16'hFFFF)
      store_cnt_d = store_cnt_q + 16'd1;

    pass_d = pass_q | (capture && pass_hit);
    fail_d = fail_q | (capture && !pass_hit && !scratch_hit);
    done_d = pass_d | fail_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      store_cnt_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      store_cnt_q <= store_cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_mem[wr_ptr_q] <= dataadr;
      data_mem[wr_ptr_q] <= writedata;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_addr  = addr_mem[rd_ptr_q];
  assign out_data  = data_mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign store_cnt = store_cnt_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign done      = done_q;

endmodule

// File: tb/tb_store_trace_buffer.sv
// Directed bench for store_trace_buffer: vector table plus
// sequences for overflow, full push/pop, stalls and mid-run reset.
module tb_store_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] store_cnt;
  logic        pass;
  logic        fail;
  logic        done;

  int errors = 0;
  int checks = 0;

  store_trace_buffer dut (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow), .store_cnt(store_cnt),
    .pass(pass), .fail(fail), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    int          e_count;
    logic        e_pass;
    logic        e_fail;
    logic        e_done;
    logic        e_ovf;
    int          e_cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [31:0] a,
                      input logic [31:0] d, input logic rd);
    reset = r; memwrite = m; dataadr = a; writedata = d; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  int q[$];
  int delivered;
  int exp_d;

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    out_ready = 1'b0;

    //        rst mw adr  dat rdy  v  addr data cnt  p  f  d  ov scnt
    tbl[0] = '{1, 0, 0,   0,  0,   0, 0,   0,   0,   0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 80,  5,  1,   1, 80,  5,   1,   0, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 84,  7,  1,   1, 84,  7,   1,   1, 0, 1, 0, 2};
    tbl[3] = '{0, 0, 0,   0,  1,   0, 0,   0,   0,   1, 0, 1, 0, 2};
    tbl[4] = '{1, 1, 84,  7,  1,   0, 0,   0,   0,   0, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 84,  6,  0,   1, 84,  6,   1,   0, 1, 1, 0, 1};
    tbl[6] = '{0, 1, 84,  7,  0,   1, 84,  6,   1,   0, 1, 1, 0, 1};
    tbl[7] = '{0, 0, 0,   0,  1,   0, 0,   0,   0,   0, 1, 1, 0, 1};
    tbl[8] = '{1, 0, 0,   0,  0,   0, 0,   0,   0,   0, 0, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].mw, tbl[i].adr, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("v%0d valid", i), out_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d addr", i), out_addr, tbl[i].e_addr);
        chk($sformatf("v%0d data", i), out_data, tbl[i].e_data);
      end
      chk($sformatf("v%0d count", i), count, tbl[i].e_count);
      chk($sformatf("v%0d pass", i), pass, tbl[i].e_pass);
      chk($sformatf("v%0d fail", i), fail, tbl[i].e_fail);
      chk($sformatf("v%0d done", i), done, tbl[i].e_done);
      chk($sformatf("v%0d overflow", i), overflow, tbl[i].e_ovf);
      chk($sformatf("v%0d store_cnt", i), store_cnt, tbl[i].e_cnt);
    end

    // overflow: 9 stores into an 8-deep FIFO with no consumer
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 32'd80, i, 1'b0);
    chk("ovf count", count, 8);
    chk("ovf flag", overflow, 1);
    chk("ovf store_cnt", store_cnt, 9);
    chk("ovf done", done, 0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf drain valid %0d", i), out_valid, 1);
      chk($sformatf("ovf drain data %0d", i), out_data, i);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("ovf empty valid", out_valid, 0);
    chk("ovf empty count", count, 0);

    // simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'd80, 10 + i, 1'b0);
    chk("full count", count, 8);
    step(1'b0, 1'b1, 32'd80, 32'd99, 1'b1);
    chk("full pp count", count, 8);
    chk("full pp overflow", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 7) ? 11 + i : 99;
      chk($sformatf("full pp data %0d", i), out_data, exp_d);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("full pp empty", out_valid, 0);

    // out_ready pattern 1,1,0,0 while storing every other cycle
    do_reset();
    q.delete();
    delivered = 0;
    for (int i = 0; i < 48; i++) begin
      logic m, r;
      m = (i < 40) && (i % 2 == 0);
      r = (i % 4) < 2;
      if (q.size() > 0 && r) begin
        void'(q.pop_front());
        delivered++;
      end
      if (m) q.push_back(200 + i / 2);
      step(1'b0, m, 32'd80, 200 + i / 2, r);
      chk($sformatf("hs valid %0d", i), out_valid, q.size() > 0);
      chk($sformatf("hs count %0d", i), count, q.size());
      if (q.size() > 0) begin
        chk($sformatf("hs data %0d", i), out_data, q[0]);
        chk($sformatf("hs addr %0d", i), out_addr, 80);
      end
    end
    chk("hs delivered", delivered, 20);
    chk("hs store_cnt", store_cnt, 20);
    chk("hs overflow", overflow, 0);

    // reset with count=5 and done=1, then re-arm
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'd80, i, 1'b0);
    step(1'b0, 1'b1, 32'd85, 32'd1, 1'b0);
    chk("mid count", count, 5);
    chk("mid done", done, 1);
    chk("mid fail", fail, 1);
    do_reset();
    chk("rst count", count, 0);
    chk("rst valid", out_valid, 0);
    chk("rst done", done, 0);
    chk("rst fail", fail, 0);
    chk("rst store_cnt", store_cnt, 0);
    step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
    chk("rearm pass", pass, 1);
    chk("rearm fail", fail, 0);
    chk("rearm done", done, 1);
    chk("rearm count", count, 1);
    chk("rearm addr", out_addr, 84);
    chk("rearm data", out_data, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
